// File: rtl/addr_seq_unit.sv
// addr_seq_unit
// Sequenced address-generation unit. Owns the program counter and the stack
// pointer and executes one control-flow or memory operation at a time. Ops that
// touch memory are run through a small state machine and a req/ack bus
// handshake. Only one bus transfer is ever outstanding.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   op_valid/op_ready   decoder handshake (ready only while idle)
//   op, op_we           operation code; store/load select for MEM
//   dx, dy              address bytes, {dy,dx} is the absolute address
//   offs, longoffs      short memory offset / jump offset {offs,longoffs}
//   wdata               store / push data
//   pc, sp              program counter and stack pointer registers
//   mem_req, mem_we     bus request and write strobe
//   mem_addr, mem_wdata registered bus address and write data
//   mem_ack, mem_rdata  bus completion and read data
//   rdata, rdata_valid  last loaded/popped byte and its one-cycle strobe
module addr_seq_unit #(
  parameter int              DW         = 8,
  parameter int              AW         = 2*DW,
  parameter int              SOFFW      = 4,
  parameter int              LOFFW      = 8,
  parameter logic [DW-1:0]   STACK_PAGE = 8'hFF,
  parameter logic [AW-1:0]   RESET_PC   = '0,
  parameter logic [DW-1:0]   RESET_SP   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic             op_we,
  input  logic [DW-1:0]    dx,
  input  logic [DW-1:0]    dy,
  input  logic [SOFFW-1:0] offs,
  input  logic [LOFFW-1:0] longoffs,
  input  logic [DW-1:0]    wdata,
  output logic [AW-1:0]    pc,
  output logic [DW-1:0]    sp,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic             mem_ack,
  input  logic [DW-1:0]    mem_rdata,
  output logic [DW-1:0]    rdata,
  output logic             rdata_valid
);

  localparam logic [2:0] OP_STEP  = 3'd0;
  localparam logic [2:0] OP_JUMP  = 3'd1;
  localparam logic [2:0] OP_LJUMP = 3'd2;
  localparam logic [2:0] OP_MEM   = 3'd3;
  localparam logic [2:0] OP_PUSH  = 3'd4;
  localparam logic [2:0] OP_POP   = 3'd5;
  localparam logic [2:0] OP_CALL  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCESS, S_CALL_HI, S_CALL_LO, S_RET_LO, S_RET_HI
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q;     // op being executed in S_ACCESS
  logic [AW-1:0]   tgt_q;    // CALL destination
  logic [DW-1:0]   byte_q;   // CALL: low return byte; RET: popped low byte
  logic            accept, ack;
  logic [AW-1:0]   pc_inc;
  logic [DW-1:0]   sp_dec1, sp_dec2, sp_inc1, sp_inc2;

  // Sign-extend the jump offset to address width.
  function automatic logic [AW-1:0] sext_jump(input logic signed [SOFFW+LOFFW-1:0] v);
    return AW'(v);
  endfunction

  // Sign-extend the short memory offset to address width.
  function automatic logic [AW-1:0] sext_short(input logic signed [SOFFW-1:0] v);
    return AW'(v);
  endfunction

  assign op_ready = (state_q == S_IDLE);
  assign accept   = op_valid && op_ready;
  // mem_req is high in every non-idle state, so an ack while idle is ignored.
  assign ack      = mem_ack && mem_req;
  assign pc_inc   = pc + AW'(1);
  assign sp_dec1  = sp - DW'(1);
  assign sp_dec2  = sp - DW'(2);
  assign sp_inc1  = sp + DW'(1);
  assign sp_inc2  = sp + DW'(2);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MEM, OP_PUSH, OP_POP: state_d = S_ACCESS;
            OP_CALL:                 state_d = S_CALL_HI;
            3'd7:                    state_d = S_RET_LO;
            default:                 state_d = S_IDLE;
          endcase
        end
      end
      S_ACCESS:  if (ack) state_d = S_IDLE;
      S_CALL_HI: if (ack) state_d = S_CALL_LO;
      S_CALL_LO: if (ack) state_d = S_IDLE;
      S_RET_LO:  if (ack) state_d = S_RET_HI;
      S_RET_HI:  if (ack) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Operand holding registers; they need no reset because they are only
  // consumed after an accept has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op;
      tgt_q  <= {dy, dx};
      byte_q <= pc_inc[DW-1:0];
    end else if (state_q == S_RET_LO && ack) begin
      byte_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      sp          <= RESET_SP;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (op)
              OP_STEP:  pc <= pc_inc;
              OP_JUMP:  pc <= pc + sext_jump($signed({offs, longoffs}));
              OP_LJUMP: pc <= {dy, dx};
              OP_MEM: begin
                mem_req   <= 1'b1;
                mem_we    <= op_we;
                mem_addr  <= {dy, dx} + sext_short($signed(offs));
                mem_wdata <= wdata;
              end
              OP_PUSH: begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= {STACK_PAGE, sp_dec1};
                mem_wdata <= wdata;
              end
              OP_POP: begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= {STACK_PAGE, sp};
              end
              OP_CALL: begin
                // High return byte goes first, at the higher stack address.
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= {STACK_PAGE, sp_dec1};
                mem_wdata <= pc_inc[AW-1:DW];
              end
              default: begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= {STACK_PAGE, sp};
              end
            endcase
          end
        end
        S_ACCESS: begin
          if (ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            pc      <= pc_inc;
            if (op_q == OP_PUSH) sp <= sp_dec1;
            if (op_q == OP_POP)  sp <= sp_inc1;
            if (op_q == OP_POP || (op_q == OP_MEM && !mem_we)) begin
              rdata       <= mem_rdata;
              rdata_valid <= 1'b1;
            end
          end
        end
        S_CALL_HI: begin
          if (ack) begin
            mem_addr  <= {STACK_PAGE, sp_dec2};
            mem_wdata <= byte_q;
          end
        end
        S_CALL_LO: begin
          if (ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            sp      <= sp_dec2;
            pc      <= tgt_q;
          end
        end
        S_RET_LO: begin
          if (ack) mem_addr <= {STACK_PAGE, sp_inc1};
        end
        S_RET_HI: begin
          if (ack) begin
            mem_req <= 1'b0;
            sp      <= sp_inc2;
            pc      <= {mem_rdata, byte_q};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_seq_unit.sv
// Testbench for addr_seq_unit: transaction-level reference model (pc/sp as
// integers, an expected-transfer queue and a reference memory image), a bus
// responder with random wait states, directed scenarios and random ops.
module tb_addr_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op = '0;
  logic        op_we = 1'b0;
  logic [7:0]  dx = '0, dy = '0, wdata = '0, longoffs = '0;
  logic [3:0]  offs = '0;
  logic [15:0] pc, mem_addr;
  logic [7:0]  sp, mem_wdata, rdata;
  logic        mem_req, mem_we, rdata_valid;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;

  addr_seq_unit dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .op_we(op_we), .dx(dx), .dy(dy), .offs(offs),
    .longoffs(longoffs), .wdata(wdata), .pc(pc), .sp(sp),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rdata(rdata), .rdata_valid(rdata_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; bit we; int wdata; } xfer_t;
  xfer_t      exp_q[$];
  logic [7:0] tbmem  [0:65535];   // memory as written by the DUT
  logic [7:0] refmem [0:65535];   // memory as the model expects it
  int m_pc = 0, m_sp = 0;
  int checks = 0, failures = 0;
  int fixed_wait = -1, ack_budget = -1, wait_left = -1, req_cycles = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bus responder and per-cycle bus checker.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      req_cycles++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bus_unexpected mem_addr=%h required=no request", mem_addr);
      end else begin
        chk("bus_addr", mem_addr, exp_q[0].addr);
        chk("bus_we", mem_we, exp_q[0].we);
        if (exp_q[0].we) chk("bus_wdata", mem_wdata, exp_q[0].wdata);
      end
      if (wait_left < 0) wait_left = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
      mem_rdata = 8'($urandom);
      if (wait_left == 0 && ack_budget != 0) begin
        mem_ack = 1'b1;
        if (mem_we) tbmem[mem_addr] = mem_wdata;
        else        mem_rdata = tbmem[mem_addr];
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        wait_left = -1;
        if (ack_budget > 0) ack_budget--;
      end else if (wait_left > 0) begin
        wait_left--;
      end
    end else begin
      // Stray acks while no request is pending must be ignored.
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
      wait_left = -1;
    end
  end

  // Reference model: final pc/sp/rdata and the bus transfers of one op.
  task automatic model_op(input int o, input bit we, input int x, input int y,
                          input int of, input int lof, input int wd,
                          output int epc, output int esp, output int erd,
                          output bit erv);
    int a, a2, sj, so, r, lo_b, hi_b;
    epc = (m_pc + 1) % 65536;
    esp = m_sp;
    erd = 0;
    erv = 1'b0;
    case (o)
      1: begin
        sj = of * 256 + lof;
        if (sj >= 2048) sj -= 4096;
        epc = (m_pc + sj + 65536) % 65536;
      end
      2: epc = y * 256 + x;
      3: begin
        so = (of >= 8) ? of - 16 : of;
        a  = (y * 256 + x + so + 65536) % 65536;
        exp_q.push_back('{a, we, wd});
        if (we) refmem[a] = 8'(wd);
        else begin erd = refmem[a]; erv = 1'b1; end
      end
      4: begin
        a = 65280 + (m_sp + 255) % 256;
        exp_q.push_back('{a, 1'b1, wd});
        refmem[a] = 8'(wd);
        esp = (m_sp + 255) % 256;
      end
      5: begin
        a = 65280 + m_sp;
        exp_q.push_back('{a, 1'b0, 0});
        erd = refmem[a];
        erv = 1'b1;
        esp = (m_sp + 1) % 256;
      end
      6: begin
        r  = (m_pc + 1) % 65536;
        a  = 65280 + (m_sp + 255) % 256;
        a2 = 65280 + (m_sp + 254) % 256;
        exp_q.push_back('{a, 1'b1, r / 256});
        exp_q.push_back('{a2, 1'b1, r % 256});
        refmem[a]  = 8'(r / 256);
        refmem[a2] = 8'(r % 256);
        esp = (m_sp + 254) % 256;
        epc = y * 256 + x;
      end
      7: begin
        a  = 65280 + m_sp;
        a2 = 65280 + (m_sp + 1) % 256;
        lo_b = refmem[a];
        hi_b = refmem[a2];
        exp_q.push_back('{a, 1'b0, 0});
        exp_q.push_back('{a2, 1'b0, 0});
        epc = hi_b * 256 + lo_b;
        esp = (m_sp + 2) % 256;
      end
      default: ;
    endcase
  endtask

  // Issue one op at a negedge and follow it to completion. Ends at a negedge
  // with op_ready high so the next op can be presented immediately.
  task automatic issue(input int o, input bit we, input int x, input int y,
                       input int of, input int lof, input int wd);
    int g, epc, esp, erd, opc, osp;
    bit erv;
    g = 0;
    while (!op_ready && g < 50) begin @(negedge clk); g++; end
    chk("ready_before_op", op_ready, 1);
    op = 3'(o); op_we = we; dx = 8'(x); dy = 8'(y);
    offs = 4'(of); longoffs = 8'(lof); wdata = 8'(wd);
    op_valid = 1'b1;
    opc = m_pc; osp = m_sp;
    model_op(o, we, x, y, of, lof, wd, epc, esp, erd, erv);
    @(negedge clk);
    op_valid = 1'b0;
    op = 3'($urandom); op_we = 1'($urandom); dx = 8'($urandom); dy = 8'($urandom);
    offs = 4'($urandom); longoffs = 8'($urandom); wdata = 8'($urandom);
    chk("rvalid_clear", rdata_valid, 0);
    g = 0;
    while (!op_ready && g < 200) begin
      chk("pc_hold", pc, opc);
      chk("sp_hold", sp, osp);
      @(negedge clk);
      g++;
    end
    chk("op_done", op_ready, 1);
    chk("pc", pc, epc);
    chk("sp", sp, esp);
    chk("xfers_left", exp_q.size(), 0);
    chk("rvalid", rdata_valid, int'(erv));
    if (erv) chk("rdata", rdata, erd);
    m_pc = epc;
    m_sp = esp;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    for (int i = 0; i < 65536; i++) begin
      tbmem[i]  = 8'($urandom);
      refmem[i] = tbmem[i];
    end

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_sp", sp, 0);
    chk("rst_ready", op_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rdata_valid, 0);
    rst_n = 1'b1;
    m_pc = 0; m_sp = 0;

    // PUSH/POP across the stack wrap
    issue(4, 1'b0, 0, 0, 0, 0, 8'hA5);
    chk("push_sp_lit", sp, 8'hFF);
    chk("push_mem_lit", tbmem[16'hFFFF], 8'hA5);
    issue(5, 1'b0, 0, 0, 0, 0, 0);
    chk("pop_sp_lit", sp, 8'h00);
    chk("pop_rdata_lit", rdata, 8'hA5);

    // Jump arithmetic wrap
    issue(2, 1'b0, 8'h10, 8'h00, 0, 0, 0);
    issue(1, 1'b0, 0, 0, 4'hF, 8'hF0, 0);
    chk("jump_lit", pc, 16'h0000);
    issue(2, 1'b0, 8'hFF, 8'hFF, 0, 0, 0);
    issue(0, 1'b0, 0, 0, 0, 0, 0);
    chk("step_wrap_lit", pc, 16'h0000);

    // MEM load with three wait states
    issue(2, 1'b0, 8'h00, 8'h01, 0, 0, 0);
    tbmem[16'h1FFE] = 8'h5A;
    refmem[16'h1FFE] = 8'h5A;
    fixed_wait = 3;
    req_cycles = 0;
    issue(3, 1'b0, 8'h00, 8'h20, 4'hE, 0, 0);
    fixed_wait = -1;
    chk("mem_req_cycles_lit", req_cycles, 4);
    chk("mem_rdata_lit", rdata, 8'h5A);
    chk("mem_pc_lit", pc, 16'h0101);
    @(negedge clk);
    chk("rvalid_one_cycle", rdata_valid, 0);

    // Back-to-back single-cycle ops with op_valid held
    op = 3'd0; op_valid = 1'b1;
    @(negedge clk);
    chk("b2b_ready1", op_ready, 1);
    chk("b2b_pc1", pc, 16'h0102);
    op = 3'd2; dx = 8'h34; dy = 8'h12;
    @(negedge clk);
    chk("b2b_ready2", op_ready, 1);
    chk("b2b_pc2", pc, 16'h1234);
    op = 3'd0;
    @(negedge clk);
    op_valid = 1'b0;
    chk("b2b_pc3", pc, 16'h1235);
    m_pc = 16'h1235;

    // Random ops against the model
    for (int n = 0; n < 300; n++) begin
      issue($urandom_range(0, 7), 1'($urandom), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 15),
            $urandom_range(0, 255), $urandom_range(0, 255));
    end

    // CALL / RET at a known pc and sp
    g = 0;
    while (m_sp != 8'h80 && g < 300) begin
      issue(5, 1'b0, 0, 0, 0, 0, 0);
      g++;
    end
    chk("sp_setup", sp, 8'h80);
    issue(2, 1'b0, 8'h34, 8'h12, 0, 0, 0);
    issue(6, 1'b0, 8'h00, 8'h40, 0, 0, 0);
    chk("call_pc_lit", pc, 16'h4000);
    chk("call_sp_lit", sp, 8'h7E);
    chk("call_hi_lit", tbmem[16'hFF7F], 8'h12);
    chk("call_lo_lit", tbmem[16'hFF7E], 8'h35);
    issue(7, 1'b0, 0, 0, 0, 0, 0);
    chk("ret_pc_lit", pc, 16'h1235);
    chk("ret_sp_lit", sp, 8'h80);

    // Reset in the middle of a CALL, after the first write is acked
    fixed_wait = 0;
    ack_budget = 1;
    op = 3'd6; dx = 8'h00; dy = 8'h50; op_valid = 1'b1;
    exp_q.push_back('{16'hFF7F, 1'b1, 8'h12});
    exp_q.push_back('{16'hFF7E, 1'b1, 8'h36});
    refmem[16'hFF7F] = 8'h12;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    chk("abort_second_addr", mem_addr, 16'hFF7E);
    chk("abort_req_held", mem_req, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_req", mem_req, 0);
    chk("abort_pc", pc, 0);
    chk("abort_sp", sp, 0);
    chk("abort_ready", op_ready, 1);
    rst_n = 1'b1;
    exp_q.delete();
    m_pc = 0; m_sp = 0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_req", mem_req, 0);
    end
    chk("abort_no_write", tbmem[16'hFF7E], 8'h35);
    fixed_wait = -1;
    ack_budget = -1;
    issue(0, 1'b0, 0, 0, 0, 0, 0);
    chk("post_reset_step_lit", pc, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
